// File: rtl/core_pkg.sv
// Shared RV32I constants, FSM state encoding and ALU operation codes.
package core_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WB
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  // SUB only exists in register form; SRAI carries the alternate bit in imm[10].
  function automatic alu_op_e alu_op_decode(input logic [2:0] f3,
                                            input logic [6:0] f7,
                                            input logic       is_reg);
    case (f3)
      F3_ADD:  return (is_reg && (f7 == F7_ALT)) ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational RV32I integer ALU: 32-bit wrap-around arithmetic, logic, shifts, compares.
module core_alu
  import core_pkg::*;
(
  input  alu_op_e     op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  // Select result by operation; shift amount is the low five bits of b.
  always_comb begin
    y_o = '0;
    case (op_i)
      ALU_ADD:  y_o = a_i + b_i;
      ALU_SUB:  y_o = a_i - b_i;
      ALU_SLL:  y_o = a_i << b_i[4:0];
      ALU_SLT:  y_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU: y_o = {31'b0, a_i < b_i};
      ALU_XOR:  y_o = a_i ^ b_i;
      ALU_SRL:  y_o = a_i >> b_i[4:0];
      ALU_SRA:  y_o = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_OR:   y_o = a_i | b_i;
      ALU_AND:  y_o = a_i & b_i;
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/core.sv
// Multicycle RV32I core: FETCH -> DECODE -> EXECUTE -> {MEM -> WB | MEM | FETCH}.
module core
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] address,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  output logic [3:0]  byte_enable,
  output logic        we
);

  state_e      state_q;
  logic [31:0] pc_q, ir_q, rs1_q, rs2_q;
  logic [31:0] addr_q, dout_q;
  logic [3:0]  be_q;
  logic        we_q;
  logic [1:0]  ea_lo_q;
  logic [31:0] regs_q [32];

  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] pc_plus4, ea, alu_b, alu_y;
  alu_op_e     alu_op;

  logic        ex_wen, is_load, is_store, br_taken;
  logic [31:0] ex_wdata, next_pc_d, st_data;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        rf_we;
  logic [31:0] rf_wdata;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u = {ir_q[31:12], 12'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  assign pc_plus4 = pc_q + 32'd4;
  assign ea       = rs1_q + ((opcode == OPC_STORE) ? imm_s : imm_i);
  assign alu_op   = alu_op_decode(funct3, funct7, opcode == OPC_OP);
  assign alu_b    = (opcode == OPC_OP) ? rs2_q : imm_i;

  core_alu u_alu (
    .op_i (alu_op),
    .a_i  (rs1_q),
    .b_i  (alu_b),
    .y_o  (alu_y)
  );

  // Execute-stage decode: register write-back, next PC, memory lanes and store data.
  always_comb begin
    ex_wen    = 1'b0;
    ex_wdata  = '0;
    next_pc_d = pc_plus4;
    is_load   = 1'b0;
    is_store  = 1'b0;
    br_taken  = 1'b0;
    case (opcode)
      OPC_LUI:   begin ex_wen = 1'b1; ex_wdata = imm_u; end
      OPC_AUIPC: begin ex_wen = 1'b1; ex_wdata = pc_q + imm_u; end
      OPC_JAL: begin
        ex_wen    = 1'b1;
        ex_wdata  = pc_plus4;
        next_pc_d = pc_q + imm_j;
      end
      OPC_JALR: begin
        ex_wen    = 1'b1;
        ex_wdata  = pc_plus4;
        next_pc_d = {ea[31:1], 1'b0};
      end
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ:  br_taken = (rs1_q == rs2_q);
          F3_BNE:  br_taken = (rs1_q != rs2_q);
          F3_BLT:  br_taken = ($signed(rs1_q) <  $signed(rs2_q));
          F3_BGE:  br_taken = ($signed(rs1_q) >= $signed(rs2_q));
          F3_BLTU: br_taken = (rs1_q <  rs2_q);
          F3_BGEU: br_taken = (rs1_q >= rs2_q);
          default: br_taken = 1'b0;
        endcase
        if (br_taken) next_pc_d = pc_q + imm_b;
      end
      OPC_LOAD:  is_load  = 1'b1;
      OPC_STORE: is_store = 1'b1;
      OPC_OPIMM, OPC_OP: begin ex_wen = 1'b1; ex_wdata = alu_y; end
      default: ;
    endcase

    case (funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << ea[1:0];
        st_data = {4{rs2_q[7:0]}};
      end
      2'b01: begin
        st_be   = ea[1] ? 4'b1100 : 4'b0011;
        st_data = {2{rs2_q[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = rs2_q;
      end
    endcase
  end

  // Load lane extraction from the word returned during WB.
  always_comb begin
    ld_byte = 8'(data_in >> {ea_lo_q, 3'b000});
    ld_half = 16'(data_in >> {ea_lo_q[1], 4'b0000});
    case (funct3)
      F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {24'b0, ld_byte};
      F3_LHU:  ld_data = {16'b0, ld_half};
      F3_LW:   ld_data = data_in;
      default: ld_data = data_in;
    endcase
  end

  assign rf_we    = ((state_q == S_EXECUTE) && ex_wen) || (state_q == S_WB);
  assign rf_wdata = (state_q == S_WB) ? ld_data : ex_wdata;

  // Register file write port; x0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (rf_we && (rd != 5'd0)) begin
      regs_q[rd] <= rf_wdata;
    end
  end

  // Control FSM; bus outputs are loaded on the transition into the state that presents them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      addr_q  <= RESET_PC;
      dout_q  <= '0;
      be_q    <= 4'b1111;
      we_q    <= 1'b0;
      ea_lo_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          ir_q    <= data_in;
          rs1_q   <= regs_q[data_in[19:15]];
          rs2_q   <= regs_q[data_in[24:20]];
          state_q <= S_EXECUTE;
        end
        S_EXECUTE: begin
          pc_q <= next_pc_d;
          if (is_load || is_store) begin
            state_q <= S_MEM;
            addr_q  <= {ea[31:2], 2'b00};
            be_q    <= st_be;
            we_q    <= is_store;
            dout_q  <= is_store ? st_data : '0;
            ea_lo_q <= ea[1:0];
          end else begin
            state_q <= S_FETCH;
            addr_q  <= next_pc_d;
            be_q    <= 4'b1111;
          end
        end
        S_MEM: begin
          we_q <= 1'b0;
          if (opcode == OPC_LOAD) begin
            state_q <= S_WB;
          end else begin
            state_q <= S_FETCH;
            addr_q  <= pc_q;
            be_q    <= 4'b1111;
            dout_q  <= '0;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          addr_q  <= pc_q;
          be_q    <= 4'b1111;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  assign address  = addr_q;
  assign data_out = dout_q;
  assign we       = we_q;
  // be_q resets to all lanes so the first fetch after release is a full-word
  // read; the lanes are forced off while reset is held.
  assign byte_enable = resetn ? be_q : 4'b0000;

endmodule

// File: tb/tb_core.sv
// Directed self-checking bench for the multicycle RV32I core.
module tb_core;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] address, data_out, data_in;
  logic [3:0]  byte_enable;
  logic        we;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .address     (address),
    .data_out    (data_out),
    .data_in     (data_in),
    .byte_enable (byte_enable),
    .we          (we)
  );

  // 4 KiB synchronous-read memory with lane writes and a bench-side load port.
  logic [31:0] mem [0:1023];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    else if (we)
      for (int i = 0; i < 4; i++)
        if (byte_enable[i]) mem[address[11:2]][8*i +: 8] <= data_out[8*i +: 8];
    data_in <= mem[address[11:2]];
  end

  logic [31:0] addr_log [0:127];
  logic [31:0] dout_log [0:127];
  logic [3:0]  be_log   [0:127];
  logic        we_log   [0:127];

  localparam logic [31:0] BR_PCS [14] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h08, 32'h0C,
                                          32'h10, 32'h14, 32'h18, 32'h20, 32'h2C, 32'h28, 32'h28};
  localparam logic [31:0] ALU_EXP [16] = '{32'h0, 32'h7FFFFFFF, 32'h1, 32'h80000000,
                                           32'hFFFFFFFF, 32'h1, 32'h0, 32'hFFFFFFFF,
                                           32'h2, 32'h1, 32'h80000000, 32'h80000000,
                                           32'h1, 32'h1, 32'h1, 32'h1040};

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] opc);
    logic [31:0] im, r1, f, d;
    im = imm; r1 = rs1; f = f3; d = rd;
    return {im[11:0], r1[4:0], f[2:0], d[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im, r1, r2, f;
    im = imm; r1 = rs1; r2 = rs2; f = f3;
    return {im[11:5], r2[4:0], r1[4:0], f[2:0], im[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im, r1, r2, f;
    im = imm; r1 = rs1; r2 = rs2; f = f3;
    return {im[12], im[10:5], r2[4:0], r1[4:0], f[2:0], im[4:1], im[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] opc);
    logic [31:0] im, d;
    im = imm20; d = rd;
    return {im[19:0], d[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] im, d;
    im = imm; d = rd;
    return {im[20], im[10:1], im[11], im[19:12], d[4:0], 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
    logic [31:0] g, r1, r2, f, d;
    g = f7; r1 = rs1; r2 = rs2; f = f3; d = rd;
    return {g[6:0], r2[4:0], r1[4:0], f[2:0], d[4:0], 7'b0110011};
  endfunction

  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] LOAD  = 7'b0000011;

  // ---------------- helpers ----------------
  task automatic poke(input int idx, input logic [31:0] val);
    ld_en = 1'b1; ld_idx = 10'(idx); ld_data = val;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic enter_reset();
    resetn = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 48; i++) poke(i, 32'h0);
    for (int i = 512; i < 516; i++) poke(i, 32'h0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    resetn = 1'b1;
    #1;
  endtask

  // Sample the bus once per cycle, starting in the current cycle.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      addr_log[i] = address; dout_log[i] = data_out;
      be_log[i] = byte_enable; we_log[i] = we;
      @(negedge clk); #1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    enter_reset();
    #1;
    n_tests++; if (address !== 32'h0) begin n_fail++; $display("FAIL reset_address: got %h want %h", address, 32'h0); end
    n_tests++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we); end
    n_tests++; if (byte_enable !== 4'b0000) begin n_fail++; $display("FAIL reset_be: got %b want 0000", byte_enable); end
    n_tests++; if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", data_out); end
  endtask

  task automatic test_addi();
    enter_reset();
    poke(0, enc_i(5, 0, 0, 1, OPIMM));
    poke(1, enc_i(3, 1, 0, 2, OPIMM));
    poke(2, enc_j(0, 0));
    release_reset();
    run(12);
    n_tests++; if (addr_log[0] !== 32'h0) begin n_fail++; $display("FAIL first_fetch_addr: got %h want 0", addr_log[0]); end
    n_tests++; if (be_log[0] !== 4'b1111) begin n_fail++; $display("FAIL first_fetch_be: got %b want 1111", be_log[0]); end
    n_tests++; if (addr_log[3] !== 32'h4) begin n_fail++; $display("FAIL alu_latency_fetch: got %h want 4", addr_log[3]); end
    n_tests++; if (addr_log[9] !== 32'h8) begin n_fail++; $display("FAIL self_loop_fetch: got %h want 8", addr_log[9]); end
    n_tests++; if (dut.regs_q[1] !== 32'd5) begin n_fail++; $display("FAIL addi_x1: got %h want 5", dut.regs_q[1]); end
    n_tests++; if (dut.regs_q[2] !== 32'd8) begin n_fail++; $display("FAIL addi_fwd_x2: got %h want 8", dut.regs_q[2]); end
  endtask

  task automatic test_store_word();
    int nwe;
    enter_reset();
    poke(0, enc_i(5, 0, 0, 1, OPIMM));
    poke(1, enc_u(1, 2, 7'b0110111));
    poke(2, enc_i(-2044, 2, 0, 2, OPIMM));
    poke(3, enc_s(0, 1, 2, 2));
    poke(4, enc_j(0, 0));
    release_reset();
    run(30);
    nwe = 0;
    for (int i = 0; i < 30; i++) if (we_log[i]) nwe++;
    n_tests++; if (nwe !== 1) begin n_fail++; $display("FAIL sw_we_count: got %0d want 1", nwe); end
    n_tests++; if (we_log[12] !== 1'b1) begin n_fail++; $display("FAIL sw_we_cycle: got %b want 1", we_log[12]); end
    n_tests++; if (addr_log[12] !== 32'h804) begin n_fail++; $display("FAIL sw_addr: got %h want 804", addr_log[12]); end
    n_tests++; if (be_log[12] !== 4'b1111) begin n_fail++; $display("FAIL sw_be: got %b want 1111", be_log[12]); end
    n_tests++; if (dout_log[12] !== 32'h5) begin n_fail++; $display("FAIL sw_data: got %h want 5", dout_log[12]); end
    n_tests++; if (addr_log[13] !== 32'h10) begin n_fail++; $display("FAIL sw_latency_fetch: got %h want 10", addr_log[13]); end
    n_tests++; if (mem[513] !== 32'h5) begin n_fail++; $display("FAIL sw_mem: got %h want 5", mem[513]); end
  endtask

  task automatic test_byte_half();
    int s;
    logic [31:0] sa [2];
    logic [31:0] sd [2];
    logic [3:0]  sb [2];
    enter_reset();
    poke(512, 32'h11223344);
    poke(0,  enc_i(32'hAB, 0, 0, 3, OPIMM));
    poke(1,  enc_i(32'h7FF, 0, 0, 4, OPIMM));
    poke(2,  enc_i(4, 4, 0, 4, OPIMM));
    poke(3,  enc_s(0, 3, 4, 0));
    poke(4,  enc_i(0, 4, 0, 5, LOAD));
    poke(5,  enc_i(0, 4, 4, 6, LOAD));
    poke(6,  enc_i(-1, 4, 1, 7, LOAD));
    poke(7,  enc_i(-1, 4, 5, 8, LOAD));
    poke(8,  enc_i(0, 4, 2, 9, LOAD));
    poke(9,  enc_s(3, 3, 4, 1));
    poke(10, enc_j(0, 0));
    release_reset();
    run(80);
    s = 0;
    sa[0] = '0; sa[1] = '0; sd[0] = '0; sd[1] = '0; sb[0] = '0; sb[1] = '0;
    for (int i = 0; i < 80; i++)
      if (we_log[i]) begin
        if (s < 2) begin sa[s] = addr_log[i]; sd[s] = dout_log[i]; sb[s] = be_log[i]; end
        s++;
      end
    n_tests++; if (s !== 2) begin n_fail++; $display("FAIL subword_store_count: got %0d want 2", s); end
    n_tests++; if (sa[0] !== 32'h800) begin n_fail++; $display("FAIL sb_addr: got %h want 800", sa[0]); end
    n_tests++; if (sb[0] !== 4'b1000) begin n_fail++; $display("FAIL sb_be: got %b want 1000", sb[0]); end
    n_tests++; if (sd[0] !== 32'hABABABAB) begin n_fail++; $display("FAIL sb_data: got %h want ABABABAB", sd[0]); end
    n_tests++; if (sa[1] !== 32'h804) begin n_fail++; $display("FAIL sh_addr: got %h want 804", sa[1]); end
    n_tests++; if (sb[1] !== 4'b1100) begin n_fail++; $display("FAIL sh_be: got %b want 1100", sb[1]); end
    n_tests++; if (sd[1] !== 32'h00AB00AB) begin n_fail++; $display("FAIL sh_data: got %h want 00AB00AB", sd[1]); end
    n_tests++; if (mem[512] !== 32'hAB223344) begin n_fail++; $display("FAIL sb_mem_merge: got %h want AB223344", mem[512]); end
    n_tests++; if (mem[513] !== 32'h00AB0000) begin n_fail++; $display("FAIL sh_mem_merge: got %h want 00AB0000", mem[513]); end
    n_tests++; if (dut.regs_q[5] !== 32'hFFFFFFAB) begin n_fail++; $display("FAIL lb: got %h want FFFFFFAB", dut.regs_q[5]); end
    n_tests++; if (dut.regs_q[6] !== 32'h000000AB) begin n_fail++; $display("FAIL lbu: got %h want 000000AB", dut.regs_q[6]); end
    n_tests++; if (dut.regs_q[7] !== 32'hFFFFAB22) begin n_fail++; $display("FAIL lh: got %h want FFFFAB22", dut.regs_q[7]); end
    n_tests++; if (dut.regs_q[8] !== 32'h0000AB22) begin n_fail++; $display("FAIL lhu: got %h want 0000AB22", dut.regs_q[8]); end
    n_tests++; if (dut.regs_q[9] !== 32'hAB223344) begin n_fail++; $display("FAIL lw_unaligned: got %h want AB223344", dut.regs_q[9]); end
  endtask

  task automatic test_branch_jump();
    enter_reset();
    poke(0,  enc_i(1, 0, 0, 1, OPIMM));
    poke(1,  enc_i(2, 0, 0, 2, OPIMM));
    poke(2,  enc_i(1, 3, 0, 3, OPIMM));
    poke(3,  enc_i(0, 0, 0, 0, OPIMM));
    poke(4,  enc_b(-8, 1, 3, 0));
    poke(5,  enc_b(8, 2, 3, 1));
    poke(6,  enc_j(8, 0));
    poke(7,  enc_i(99, 0, 0, 4, OPIMM));
    poke(8,  enc_j(12, 1));
    poke(9,  enc_i(77, 0, 0, 4, OPIMM));
    poke(10, enc_j(0, 0));
    poke(11, enc_i(5, 1, 0, 5, 7'b1100111));
    release_reset();
    run(45);
    for (int k = 0; k < 14; k++) begin
      n_tests++;
      if (addr_log[3*k] !== BR_PCS[k]) begin
        n_fail++; $display("FAIL fetch_seq[%0d]: got %h want %h", k, addr_log[3*k], BR_PCS[k]);
      end
    end
    n_tests++; if (dut.regs_q[1] !== 32'h24) begin n_fail++; $display("FAIL jal_link: got %h want 24", dut.regs_q[1]); end
    n_tests++; if (dut.regs_q[3] !== 32'h2) begin n_fail++; $display("FAIL loop_count: got %h want 2", dut.regs_q[3]); end
    n_tests++; if (dut.regs_q[4] !== 32'h0) begin n_fail++; $display("FAIL skipped_instr: got %h want 0", dut.regs_q[4]); end
    n_tests++; if (dut.regs_q[5] !== 32'h30) begin n_fail++; $display("FAIL jalr_link: got %h want 30", dut.regs_q[5]); end
  endtask

  task automatic test_alu();
    enter_reset();
    poke(0,  enc_u(32'h80000, 1, 7'b0110111));
    poke(1,  enc_i(-1, 1, 0, 1, OPIMM));
    poke(2,  enc_i(1, 0, 0, 2, OPIMM));
    poke(3,  enc_r(0, 2, 1, 0, 3));
    poke(4,  enc_i(-1, 0, 0, 4, OPIMM));
    poke(5,  enc_r(0, 2, 4, 2, 5));
    poke(6,  enc_r(0, 2, 4, 3, 6));
    poke(7,  enc_i(32'h41F, 3, 5, 7, OPIMM));
    poke(8,  enc_i(1, 0, 0, 0, OPIMM));
    poke(9,  enc_r(32, 4, 2, 0, 8));
    poke(10, enc_i(31, 3, 5, 9, OPIMM));
    poke(11, enc_r(0, 4, 2, 1, 10));
    poke(12, enc_r(0, 4, 1, 4, 11));
    poke(13, enc_r(0, 2, 0, 0, 12));
    poke(14, enc_i(0, 4, 2, 13, OPIMM));
    poke(15, enc_i(-1, 2, 3, 14, OPIMM));
    poke(16, enc_u(1, 15, 7'b0010111));
    poke(17, enc_j(0, 0));
    release_reset();
    run(60);
    for (int r = 0; r < 16; r++) begin
      n_tests++;
      if (dut.regs_q[r] !== ALU_EXP[r]) begin
        n_fail++; $display("FAIL alu_x%0d: got %h want %h", r, dut.regs_q[r], ALU_EXP[r]);
      end
    end
  endtask

  task automatic test_reset_abort();
    int nwe;
    enter_reset();
    poke(0, enc_i(7, 0, 0, 1, OPIMM));
    poke(1, enc_s(32'h100, 1, 0, 2));
    poke(2, enc_j(0, 0));
    release_reset();
    run(5);
    resetn = 1'b0;
    nwe = 0;
    for (int i = 0; i < 3; i++) begin
      if (we) nwe++;
      @(negedge clk); #1;
    end
    n_tests++; if (nwe !== 0) begin n_fail++; $display("FAIL abort_we: got %0d pulses want 0", nwe); end
    n_tests++; if (mem[64] !== 32'h0) begin n_fail++; $display("FAIL abort_mem: got %h want 0", mem[64]); end
    n_tests++; if (dut.regs_q[1] !== 32'h0) begin n_fail++; $display("FAIL abort_rf_clear: got %h want 0", dut.regs_q[1]); end
    n_tests++; if (address !== 32'h0) begin n_fail++; $display("FAIL abort_addr: got %h want 0", address); end
    release_reset();
    run(12);
    n_tests++; if (addr_log[0] !== 32'h0 || be_log[0] !== 4'b1111) begin
      n_fail++; $display("FAIL restart_fetch: got %h/%b want 0/1111", addr_log[0], be_log[0]);
    end
    n_tests++; if (we_log[6] !== 1'b1 || addr_log[6] !== 32'h100 || dout_log[6] !== 32'h7) begin
      n_fail++; $display("FAIL restart_store: got we=%b addr=%h data=%h want 1/100/7", we_log[6], addr_log[6], dout_log[6]);
    end
  endtask

  initial begin
    resetn = 1'b0;
    test_reset();
    test_addi();
    test_store_word();
    test_byte_half();
    test_branch_jump();
    test_alu();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
